// File: rtl/traffic_lamp_driver_if.sv
// Color-code input and lamp/fault output bundle between the light sequencer and the lamp driver.
interface traffic_lamp_driver_if;
  logic [2:0] color_i;
  logic       hold_i;
  logic       dim_i;
  logic       clr_fault_i;
  logic [2:0] lamp_o;
  logic       fault_o;
  logic [1:0] fault_code_o;

  modport master (
    output color_i, hold_i, dim_i, clr_fault_i,
    input  lamp_o, fault_o, fault_code_o
  );

  modport slave (
    input  color_i, hold_i, dim_i, clr_fault_i,
    output lamp_o, fault_o, fault_code_o
  );
endinterface

// File: rtl/traffic_lamp_driver.sv
// Lamp driver: PWM-dimmed lamp outputs one cycle after the color sample, with a supervisor
// that latches a flashing-yellow failsafe on multi-hot codes, illegal steps or stuck colors.
module traffic_lamp_driver #(
  parameter int PWM_PERIOD = 8,
  parameter int DUTY_NIGHT = 3,
  parameter int FLASH_HALF = 4,
  parameter int STUCK_MAX  = 64
) (
  input logic                  clk,
  input logic                  rstn,
  traffic_lamp_driver_if.slave bus
);
  localparam int PW = $clog2(PWM_PERIOD);
  localparam int SW = $clog2(STUCK_MAX);
  localparam int FW = $clog2(FLASH_HALF) + 1;
  localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_PERIOD - 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_MAX - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [2:0] C_G = 3'b001;
  localparam logic [2:0] C_Y = 3'b010;
  localparam logic [2:0] C_R = 3'b100;
  localparam logic [2:0] C_D = 3'b000;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    prev_q, prev_d;
  logic [SW-1:0] stuck_q, stuck_d;
  logic [PW-1:0] pwm_q, pwm_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          flash_on_q, flash_on_d;
  logic [2:0]    lamp_q, lamp_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [PW:0]   duty;
  logic          pwm_on;
  logic          multi_hot;
  logic          step_ok;
  logic [1:0]    det_code;

  always_comb begin
    duty      = bus.dim_i ? (PW+1)'(DUTY_NIGHT) : (PW+1)'(PWM_PERIOD);
    pwm_on    = ({1'b0, pwm_q} < duty);
    pwm_d     = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    multi_hot = ((bus.color_i & (bus.color_i - 3'd1)) != 3'd0);
    case (prev_q)
      C_G:     step_ok = bus.color_i inside {C_G, C_Y, C_D};
      C_Y:     step_ok = bus.color_i inside {C_Y, C_R};
      C_R:     step_ok = bus.color_i inside {C_R, C_G};
      C_D:     step_ok = bus.color_i inside {C_D, C_G, C_Y};
      default: step_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    stuck_d    = stuck_q;
    flash_d    = flash_q;
    flash_on_d = flash_on_q;
    lamp_d     = lamp_q;
    fault_d    = fault_q;
    code_d     = code_q;
    det_code   = 2'b00;
    case (state_q)
      S_FAULT: begin
        if (flash_q == FLASH_LAST) begin
          flash_d    = '0;
          flash_on_d = ~flash_on_q;
        end else begin
          flash_d = flash_q + 1'b1;
        end
        lamp_d = {1'b0, flash_on_d, 1'b0};
        if (bus.clr_fault_i) begin
          state_d = S_INIT;
          prev_d  = C_D;
          stuck_d = '0;
          lamp_d  = 3'b000;
          fault_d = 1'b0;
          code_d  = 2'b00;
        end
      end
      default: begin
        lamp_d = bus.color_i & {3{pwm_on}};
        // Priority: multi-hot, then illegal step, then stuck; a code change resets stuck.
        if (multi_hot) begin
          det_code = 2'b01;
        end else if (state_q == S_INIT) begin
          prev_d  = bus.color_i;
          stuck_d = '0;
          state_d = S_RUN;
        end else if (!step_ok) begin
          det_code = 2'b10;
        end else if (bus.color_i != prev_q) begin
          prev_d  = bus.color_i;
          stuck_d = '0;
        end else if (bus.color_i != C_D && !bus.hold_i) begin
          if (stuck_q == STUCK_LAST) det_code = 2'b11;
          else                       stuck_d  = stuck_q + 1'b1;
        end
        if (det_code != 2'b00) begin
          state_d    = S_FAULT;
          fault_d    = 1'b1;
          code_d     = det_code;
          flash_d    = '0;
          flash_on_d = 1'b1;
          lamp_d     = 3'b010;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_INIT;
      prev_q     <= C_D;
      stuck_q    <= '0;
      pwm_q      <= '0;
      flash_q    <= '0;
      flash_on_q <= 1'b1;
      lamp_q     <= 3'b000;
      fault_q    <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      stuck_q    <= stuck_d;
      pwm_q      <= pwm_d;
      flash_q    <= flash_d;
      flash_on_q <= flash_on_d;
      lamp_q     <= lamp_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
    end
  end

  assign bus.lamp_o       = lamp_q;
  assign bus.fault_o      = fault_q;
  assign bus.fault_code_o = code_q;
endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
Downstream stage of top_traffic_light. Consumes its one-hot color code (GREEN=001, YELLOW=010, RED=100, 000 = dark during green blink) and drives the physical lamp outputs with day/night PWM dimming. Supervises the code stream for multi-hot codes, illegal sequence steps and stuck colors. On any fault it latches a failsafe flashing-yellow mode until software clears it.

Parameters:
PWM_PERIOD, 8, PWM frame length in clk cycles (>=2)
DUTY_NIGHT, 3, lamp-on cycles per PWM frame when dim_i=1 (1..PWM_PERIOD)
FLASH_HALF, 4, cycles per on/off half-period of the failsafe yellow flash (>=1)
STUCK_MAX, 64, max consecutive unheld samples of one non-dark code before a stuck fault (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rstn  input  1  synchronous active-low reset
color_i  input  3  color code from top_traffic_light color_out
hold_i  input  1  high while upstream is paused (top en_i low); freezes stuck supervision
dim_i  input  1  1 = night duty DUTY_NIGHT, 0 = full duty
clr_fault_i  input  1  single-cycle pulse; leaves failsafe
lamp_o  output  3  {red, yellow, green} lamp drive, registered
fault_o  output  1  latched fault flag, registered
fault_code_o  output  2  01 multi-hot, 10 illegal step, 11 stuck, 00 none

Behaviour:
- One clock, synchronous active-low reset (rstn sampled on posedge clk). Reset: lamp_o=000, fault_o=0, fault_code_o=00, state INIT, prev code=000, stuck_cnt=0, pwm_cnt=0, flash_cnt=0, flash_on=1.
- Reset mid-operation (including in FAULT) returns everything to reset values on that edge, and the fault is cleared.
- pwm_cnt free-runs 0..PWM_PERIOD-1 and wraps. pwm_on = (pwm_cnt < duty), where duty = dim_i ? DUTY_NIGHT : PWM_PERIOD. dim_i takes effect on the next edge.
- States: INIT (no prior code), RUN, FAULT.
- INIT: any code is checked for multi-hot only. A legal code is stored as prev and the state moves to RUN. No step check is done in INIT.
- RUN, per sample:
  - multi-hot (011,101,110,111) -> fault 01.
  - Legal steps: same->same, G->Y, Y->R, R->G, G->000, 000->G, 000->Y. Any other step -> fault 10 (e.g. G->R, Y->G, R->Y, R->000, Y->000, 000->R).
  - Multi-hot has priority over illegal step in the same cycle.
- Stuck counter:
  - Code change -> stuck_cnt=0.
  - Unchanged non-dark code with hold_i=0: if stuck_cnt==STUCK_MAX-1 -> fault 11, else stuck_cnt+1.
  - hold_i=1 or dark code: stuck_cnt holds its value.
  - A code change on the same edge always wins over stuck detection.
  - Net effect: the fault triggers on the (STUCK_MAX+1)th consecutive unheld sample of the same code.
- RUN output: lamp_o <= color_i & {3{pwm_on}}, using the color sampled on this edge, so latency is 1 cycle.
- Fault entry (on the detecting edge):
  - fault_o<=1 and fault_code_o set. First fault wins; later detections are ignored while in FAULT.
  - flash_cnt=0, flash_on=1, lamp_o<=010 immediately.
- FAULT:
  - lamp_o = {0, flash_on, 0}; no PWM, always full brightness.
  - flash_cnt counts 0..FLASH_HALF-1; on wrap flash_on toggles.
  - color_i, hold_i and dim_i are ignored.
- clr_fault_i in FAULT: next edge -> fault_o=0, fault_code_o=00, lamp_o=000, stuck_cnt=0, state INIT. No fault detection happens on that same edge.
- clr_fault_i outside FAULT has no effect.
- Widths: pwm_cnt is $clog2(PWM_PERIOD) bits, stuck_cnt is $clog2(STUCK_MAX) bits, flash_cnt is $clog2(FLASH_HALF)+1 bits. None of these counters may overflow.

Test Plan:
- Reset, dim_i=0, sequence G(10 cycles)->Y(5)->R(15)->G -> lamp_o equals color_i delayed 1 cycle, and fault_o stays 0.
- dim_i=1, color_i=RED held 16 cycles, hold_i=1 -> lamp_o=100 for 3 of every 8 cycles, aligned to pwm_cnt 0..2; no stuck fault.
- Green blink G,000,G,000,G then Y -> no fault. Then apply G directly after R, then R directly after G -> fault_o=1 and fault_code_o=10 on the first edge of the illegal step.
- color_i=110 in RUN -> the next cycle shows fault_o=1, fault_code_o=01, lamp_o=010. Yellow is then on 4 cycles and off 4 cycles, repeating. Changing color_i during this has no effect.
- GREEN held with hold_i=0, STUCK_MAX=64 -> fault_code_o=11 on the 65th sample. Repeat with hold_i=1 for 20 cycles mid-run -> the fault moves to the 85th sample.
- In FAULT, pulse clr_fault_i -> fault_o=0 and lamp_o=000, then state INIT accepts RED with no fault. Separately, drop rstn during FAULT -> all outputs are 000/0 after one edge.
